// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types and code constants for the Huffman stream decoder
package huff_pkg;

    localparam int SYM_W = 3;

    typedef logic [SYM_W-1:0] sym_t;

    // Symbol produced by each complete code word
    localparam sym_t SYM_CODE_0    = 3'd1;
    localparam sym_t SYM_CODE_100  = 3'd3;
    localparam sym_t SYM_CODE_101  = 3'd2;
    localparam sym_t SYM_CODE_111  = 3'd4;
    localparam sym_t SYM_CODE_1101 = 3'd5;
    localparam sym_t SYM_CODE_1100 = 3'd6;

    // Position in the code tree: the bits of a partial code seen so far
    typedef enum logic [2:0] {
        W_ROOT,
        W_P1,
        W_P10,
        W_P11,
        W_P110
    } walk_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_SHIFT,
        C_STALL
    } ctrl_state_t;

endpackage

// File: rtl/huff_code_walk.sv
// rtl/huff_code_walk.sv - code-tree walker, one coded bit per enabled cycle
// sym_done/sym_code are combinational for the bit presented this cycle, so the
// caller can push the symbol on the same edge that consumes the completing bit.
// clear drops any partial code (used on flush).
module huff_code_walk
    import huff_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_en,
    output logic sym_done,
    output sym_t sym_code,
    output logic at_root
);

    walk_state_t r_state;
    walk_state_t w_next;
    logic        w_done;
    sym_t        w_code;

    // Next tree position and completed symbol for the current bit
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_code = '0;
        case (r_state)
            W_ROOT: begin
                if (bit_in) begin
                    w_next = W_P1;
                end else begin
                    w_done = 1'b1;
                    w_code = SYM_CODE_0;
                end
            end
            W_P1: begin
                w_next = bit_in ? W_P11 : W_P10;
            end
            W_P10: begin
                w_done = 1'b1;
                w_code = bit_in ? SYM_CODE_101 : SYM_CODE_100;
                w_next = W_ROOT;
            end
            W_P11: begin
                if (bit_in) begin
                    w_done = 1'b1;
                    w_code = SYM_CODE_111;
                    w_next = W_ROOT;
                end else begin
                    w_next = W_P110;
                end
            end
            W_P110: begin
                w_done = 1'b1;
                w_code = bit_in ? SYM_CODE_1101 : SYM_CODE_1100;
                w_next = W_ROOT;
            end
            default: begin
                w_next = W_ROOT;
            end
        endcase
    end

    // Advance only on enabled bits; clear returns to the root
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= W_ROOT;
        end else if (clear) begin
            r_state <= W_ROOT;
        end else if (bit_en) begin
            r_state <= w_next;
        end
    end

    assign sym_done = w_done && bit_en;
    assign sym_code = bit_en ? w_code : '0;
    assign at_root  = (r_state == W_ROOT);

endmodule

// File: rtl/huff_stream_ctrl.sv
// rtl/huff_stream_ctrl.sv - byte-in, symbol-out Huffman stream decoder with output FIFO
// Optional feature: define HUFF_SYM_COUNT_EN to add the 16-bit sym_count output
// counting symbols handed out on the sym_valid/sym_ready handshake.
module huff_stream_ctrl
    import huff_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output sym_t       sym,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       code_pending,
    output logic       busy
`ifdef HUFF_SYM_COUNT_EN
    ,
    output logic [15:0] sym_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    ctrl_state_t   r_state;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    sym_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_room;
    logic w_consume;
    logic w_last;
    logic w_in_ready;
    logic w_accept;
    logic w_push;
    sym_t w_sym_code;
    logic w_at_root;

    // A bit may be consumed when the FIFO has a free slot, counting a slot
    // freed by a pop on the same edge; flush overrides everything.
    assign w_pop      = (r_count != '0) && sym_ready;
    assign w_room     = (r_count < DEPTH_C) || w_pop;
    assign w_consume  = (r_state == C_SHIFT) && w_room && !flush;
    assign w_last     = w_consume && (r_bit_cnt == 3'd0);
    assign w_in_ready = !flush && ((r_state == C_IDLE) || w_last);
    assign w_accept   = in_valid && w_in_ready;

    huff_code_walk u_walk (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .bit_in   (r_shift[7]),
        .bit_en   (w_consume),
        .sym_done (w_push),
        .sym_code (w_sym_code),
        .at_root  (w_at_root)
    );

    // Control FSM: load bytes, shift out one bit per cycle, stall on a full FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= C_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (flush) begin
            r_state   <= C_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= in_byte;
                        r_bit_cnt <= 3'd7;
                        r_state   <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    if (w_consume) begin
                        if (r_bit_cnt == 3'd0) begin
                            if (w_accept) begin
                                r_shift   <= in_byte;
                                r_bit_cnt <= 3'd7;
                            end else begin
                                r_shift <= '0;
                                r_state <= C_IDLE;
                            end
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end else begin
                        r_state <= C_STALL;
                    end
                end
                C_STALL: begin
                    if (w_room) begin
                        r_state <= C_SHIFT;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sym_code;
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge both take effect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

`ifdef HUFF_SYM_COUNT_EN
    // Count delivered symbols; survives flush, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_count <= '0;
        end else if (w_pop) begin
            sym_count <= sym_count + 16'd1;
        end
    end
`endif

    assign in_ready     = w_in_ready;
    assign sym_valid    = (r_count != '0);
    assign sym          = sym_valid ? r_mem[r_rd_ptr] : '0;
    assign code_pending = !w_at_root;
    assign busy         = (r_state != C_IDLE) || sym_valid;

endmodule

// File: doc/huff_stream_ctrl.md
HUFF_STREAM_CTRL -- requirements
Module: huff_stream_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, decoded-symbol FIFO depth; power of two, 2..16.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_byte  input  8  coded byte, consumed MSB-first.
REQ-005 in_valid / in_ready  input / output  1 / 1  byte handshake; a byte transfers on a clk edge where both are 1.
REQ-006 flush  input  1  one-cycle pulse: abandon current byte and partial code.
REQ-007 sym  output  3  decoded symbol, 1..6; 0 never presented as valid.
REQ-008 sym_valid / sym_ready  output / input  1 / 1  symbol handshake; a symbol transfers on a clk edge where both are 1.
REQ-009 code_pending  output  1  walker not at root, i.e. a partial code is held.
REQ-010 busy  output  1  FSM not IDLE or FIFO non-empty.

Function
REQ-011 Code table: 0->1, 100->3, 101->2, 111->4, 1101->5, 1100->6; walker states ROOT, P1, P10, P11, P110.
REQ-012 Control FSM states: IDLE, SHIFT, STALL.
REQ-013 IDLE: in_ready=1; on byte accept, load shift register and bit_cnt=7, then go to SHIFT.
REQ-014 SHIFT: consume one bit per cycle (shift_reg[7]) when FIFO count<FIFO_DEPTH or a pop occurs on the same edge; otherwise go to STALL without consuming.
REQ-015 STALL: hold bit and walker; return to SHIFT on the first cycle the consume condition of REQ-014 holds.
REQ-016 A bit that completes a code writes its symbol into the FIFO on the same edge; the walker returns to ROOT.
REQ-017 Latency: sym_valid rises on the cycle after the edge that consumed the completing bit.
REQ-018 While in SHIFT with bit_cnt==0 and the bit consumed, in_ready=1; a byte accepted then starts on the next cycle, giving 1 bit/clk sustained; with no byte, go to IDLE.
REQ-019 Codes span byte boundaries; the walker state is kept across bytes and across IDLE.
REQ-020 The FIFO is first-in first-out, and push and pop on the same edge when full or empty are both honoured; it never overflows and never underflows.
REQ-021 flush has priority over everything else: in_ready is forced to 0 on that cycle, the shift register is dropped, the walker returns to ROOT, the FSM goes to IDLE, and the FIFO is retained.
REQ-022 sym and sym_valid are held stable while sym_valid=1 and sym_ready=0.

Reset
REQ-023 Reset forces IDLE, walker ROOT, FIFO empty and bit_cnt=0, from any state including mid-byte.
REQ-024 Reset output values: in_ready=1, sym=0, sym_valid=0, code_pending=0, busy=0.

Configuration
REQ-025 Macro HUFF_SYM_COUNT_EN defined: add output sym_count, width 16, which counts symbols transferred out (REQ-008), wraps 0xFFFF->0, and is reset to 0 by reset but not by flush.
REQ-026 Macro HUFF_SYM_COUNT_EN undefined: port and counter are absent, and behaviour is otherwise identical.

Structure
REQ-027 Shared package huff_pkg holds: the walker-state and control-FSM-state typedefs, symbol width 3, and the six symbol code constants.
REQ-028 The walker is sub-module huff_code_walk: inputs bit_in and bit_en; outputs sym_done, sym_code and at_root; it changes state only when bit_en=1.
REQ-029 FIFO and control FSM stay in huff_stream_ctrl.

Verification
REQ-030 Stream test: sym_ready=1, send byte 0x00 -> eight symbols of value 1 on consecutive cycles, and code_pending=0 afterwards.
REQ-031 Cross-byte test: send 0x97 then 0x00 back-to-back -> symbols 3,2,6,1,1,1,1,1,1 in order, and code_pending=1 between the bytes.
REQ-032 Backpressure test: sym_ready=0, send 0x00 -> FIFO fills with 4 symbols, FSM enters STALL, and in_ready=0; then raise sym_ready -> all 8 symbols delivered in order with none lost or duplicated.
REQ-033 Flush test: send 0xD0 and pulse flush after 3 bits are consumed -> no symbol is emitted, code_pending=0, and the next byte 0x00 yields eight symbols of value 1.
REQ-034 Reset test: assert reset mid-byte with 2 symbols queued -> all outputs take their REQ-024 values asynchronously, and after release 0x00 decodes normally; with HUFF_SYM_COUNT_EN defined, sym_count=0 after reset and sym_count=8 after the 0x00 byte is drained.
